md_unit: RTL

Multi-cycle multiply/divide unit that owns the HI/LO register pair in the E stage of the pipelined MIPS core.
- Executes the MD operations that the control unit decodes (mult/multu/div/divu/mthi/mtlo) and serves mfhi/mflo reads.
- Exports busy so the hazard unit can stall a following MD-class instruction in D.
- Acts as the responder side of the decoder's MD request interface.

---
 rtl/md_unit_pkg.sv | 16 +
 rtl/md_arith.sv | 43 ++++
 rtl/md_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: MD op codes, FSM state encodings and default cycle counts.
package md_unit_pkg;
  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MADD  = 4'd7;
  localparam logic [3:0] MD_OP_MADDU = 4'd8;
  localparam logic [3:0] MD_OP_MSUB  = 4'd9;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} md_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {hi,lo} result for a captured MD op.
// MD_MADD_EN adds the MADD/MADDU/MSUB accumulate ops.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a_q,
  input  logic [31:0] b_q,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);
  logic        b_zero;
  logic [31:0] b_div, a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic [63:0] acc, p_s, p_u;
  assign acc    = {hi, lo};
  assign b_zero = b_q == 32'd0;
  assign b_div  = b_zero ? 32'd1 : b_q;
  // Signed divide works on magnitudes so MIN_INT / -1 wraps cleanly to MIN_INT.
  assign a_mag  = a_q[31] ? -a_q : a_q;
  assign b_mag  = b_q[31] ? -b_q : b_div;
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign q_s    = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
  assign r_s    = a_q[31] ? -r_mag : r_mag;
  assign p_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign p_u    = {32'd0, a_q} * {32'd0, b_q};
  always_comb begin
    res = acc;
    case (op)
      MD_OP_MULT:  res = p_s;
      MD_OP_MULTU: res = p_u;
      MD_OP_DIV:   res = b_zero ? acc : {r_s, q_s};
      MD_OP_DIVU:  res = b_zero ? acc : {b_q == 32'd0 ? 32'd0 : a_q % b_div, a_q / b_div};
`ifdef MD_MADD_EN
      MD_OP_MADD:  res = acc + p_s;
      MD_OP_MADDU: res = acc + p_u;
      MD_OP_MSUB:  res = acc - p_s;
`endif
      default:     res = acc;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO, with busy for hazard stalls.
// Define MD_MADD_EN to accept MADD/MADDU/MSUB (codes 7-9).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);
  localparam int CW = 16;
  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res;
  logic        is_mul, is_div;
  assign is_div = md_op == MD_OP_DIV || md_op == MD_OP_DIVU;
`ifdef MD_MADD_EN
  assign is_mul = md_op == MD_OP_MULT || md_op == MD_OP_MULTU || md_op == MD_OP_MADD ||
                  md_op == MD_OP_MADDU || md_op == MD_OP_MSUB;
`else
  assign is_mul = md_op == MD_OP_MULT || md_op == MD_OP_MULTU;
`endif
  md_arith u_arith (.op(op_q), .a_q(a_q), .b_q(b_q), .hi(hi_q), .lo(lo_q), .res(res));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start && (is_mul || is_div)) begin
        op_d    = md_op;
        a_d     = a;
        b_d     = b;
        cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_d = ST_RUN;
      end else if (start && md_op == MD_OP_MTHI) begin
        hi_d = a;
      end else if (start && md_op == MD_OP_MTLO) begin
        lo_d = a;
      end
    end else begin
      // Requests arriving in RUN are dropped; the hazard unit never sends them.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        {hi_d, lo_d} = res;
        state_d      = ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy   = state_q == ST_RUN;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = rd_hi ? hi_q : lo_q;
endmodule
